// File: rtl/sb_bus_pkg.sv
// Shared definitions for the sb bus memory slave: widths, FSM states, helpers.
package sb_bus_pkg;

    localparam int SB_DATA_W  = 32;
    localparam int SB_BURST_W = 8;
    localparam int SB_BE_W    = 4;
    localparam int SB_WAIT_W  = 4;
    localparam int SB_BEATS_W = SB_BURST_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_RD_END   = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_ERR      = 3'd5
    } sb_state_e;

    // The bus encodes burst length as beats minus one; widen and add it back.
    function automatic logic [SB_BEATS_W-1:0] sb_beat_count(input logic [SB_BURST_W-1:0] burst);
        return {1'b0, burst} + 9'd1;
    endfunction

endpackage

// File: rtl/sb_mem_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
module sb_mem_ram
    import sb_bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 we_i,
    input  logic [SB_BE_W-1:0]   be_i,
    input  logic [SB_DATA_W-1:0] wdata_i,
    output logic [SB_DATA_W-1:0] rdata_o
);

    logic [SB_DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [SB_DATA_W-1:0] rdata_q;

    // Byte-lane writes and a read-first registered read port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < SB_BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sb_mem_slave.sv
// Memory slave on the multiplexed sb bus: burst reads with fixed latency,
// burst writes with optional initial stall, and range checking of the window.
module sb_mem_slave
    import sb_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
    parameter int          MEM_WORDS_LOG2 = 10,
    parameter int          READ_WAIT      = 2,
    parameter int          WRITE_WAIT     = 0
) (
    input  logic                  sb_clock_i,
    input  logic                  sb_reset_n_i,
    input  logic                  sb_begin_transaction_i,
    input  logic [SB_DATA_W-1:0]  sb_address_data_i,
    input  logic [SB_BURST_W-1:0] sb_burst_size_i,
    input  logic                  sb_read_n_write_i,
    input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
    input  logic                  sb_data_valid_i,
    input  logic                  sb_end_transaction_i,
    input  logic                  sb_error_i,
    output logic [SB_DATA_W-1:0]  sb_address_data_o,
    output logic                  sb_data_valid_o,
    output logic                  sb_end_transaction_o,
    output logic                  sb_busy_o,
    output logic                  sb_error_o
);

    localparam int             IDX_W       = MEM_WORDS_LOG2;
    localparam logic [31:0]    WIN_MASK    = 32'((64'd1 << (MEM_WORDS_LOG2 + 2)) - 64'd1);
    localparam logic [31:0]    LAST_IDX    = 32'((64'd1 << MEM_WORDS_LOG2) - 64'd1);
    localparam logic [SB_WAIT_W-1:0] RD_WAIT_CYC = SB_WAIT_W'(READ_WAIT);
    localparam logic [SB_WAIT_W-1:0] WR_WAIT_CYC = SB_WAIT_W'(WRITE_WAIT);

    sb_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SB_BEATS_W-1:0]  beats_q, beats_d;
    logic [SB_WAIT_W-1:0]   wait_q, wait_d;
    logic [SB_BE_W-1:0]     be_q, be_d;
    logic                   dv_q, dv_d;
    logic                   end_q, end_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic [IDX_W-1:0]       req_idx_s;
    logic [31:0]            span_s;
    logic                   hit_s;
    logic                   range_ok_s;
    logic                   abort_s;
    logic                   wr_fire_s;
    logic [IDX_W-1:0]       ram_addr_s;
    logic [SB_DATA_W-1:0]   ram_rdata_s;

    // Decode of the request word: window hit, start index and end-of-burst range.
    assign req_idx_s  = sb_address_data_i[IDX_W+1:2];
    assign hit_s      = ((sb_address_data_i ^ BASE_ADDRESS) & ~WIN_MASK) == 32'd0;
    assign span_s     = 32'(req_idx_s) + 32'(sb_burst_size_i);
    assign range_ok_s = (span_s <= LAST_IDX);
    assign abort_s    = sb_error_i | sb_end_transaction_i;

    // A write beat lands only once the stall is over and beats remain; an
    // arbiter error in the same cycle cancels it.
    assign wr_fire_s = (state_q == ST_WR_DATA) && sb_data_valid_i && (wait_q == 4'd0) &&
                       (beats_q != 9'd0) && !sb_error_i && sb_reset_n_i;

    // During writes the RAM addresses the current word; otherwise it reads the
    // word that the next cycle will present, so the registered read lines up.
    assign ram_addr_s = wr_fire_s ? idx_q : idx_d;

    // Next-state, counters and the values the output registers will take.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        wait_d  = wait_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (sb_begin_transaction_i && hit_s) begin
                    if (!range_ok_s) begin
                        state_d = ST_ERR;
                    end else begin
                        idx_d   = req_idx_s;
                        beats_d = sb_beat_count(sb_burst_size_i);
                        be_d    = sb_byte_enables_i;
                        if (sb_read_n_write_i) begin
                            wait_d  = RD_WAIT_CYC;
                            state_d = (RD_WAIT_CYC == 4'd0) ? ST_RD_BURST : ST_RD_WAIT;
                        end else begin
                            wait_d  = WR_WAIT_CYC;
                            state_d = ST_WR_DATA;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if (wait_q <= 4'd1) begin
                    state_d = ST_RD_BURST;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RD_BURST: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    beats_d = beats_q - 9'd1;
                    if (beats_q <= 9'd1) begin
                        state_d = ST_RD_END;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RD_END: begin
                state_d = ST_IDLE;
            end
            ST_WR_DATA: begin
                if (wr_fire_s) begin
                    idx_d   = idx_q + IDX_W'(1);
                    beats_d = beats_q - 9'd1;
                end else begin
                    idx_d   = idx_q;
                    beats_d = beats_q;
                end
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    wait_d = wait_q;
                end
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dv_d   = (state_d == ST_RD_BURST);
        end_d  = (state_d == ST_RD_END);
        err_d  = (state_d == ST_ERR);
        busy_d = (state_d == ST_WR_DATA) && (wait_d != 4'd0);
    end

    // State, counters and registered bus outputs with synchronous active-low reset.
    always_ff @(posedge sb_clock_i) begin
        if (!sb_reset_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            beats_q <= 9'd0;
            wait_q  <= 4'd0;
            be_q    <= 4'd0;
            dv_q    <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            wait_q  <= wait_d;
            be_q    <= be_d;
            dv_q    <= dv_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    sb_mem_ram #(
        .ADDR_W (MEM_WORDS_LOG2)
    ) u_ram (
        .clk_i   (sb_clock_i),
        .addr_i  (ram_addr_s),
        .we_i    (wr_fire_s),
        .be_i    (be_q),
        .wdata_i (sb_address_data_i),
        .rdata_o (ram_rdata_s)
    );

    // Wired-OR bus: the data lines are zero whenever no read beat is driven.
    assign sb_address_data_o    = dv_q ? ram_rdata_s : 32'd0;
    assign sb_data_valid_o      = dv_q;
    assign sb_end_transaction_o = end_q;
    assign sb_busy_o            = busy_q;
    assign sb_error_o           = err_q;

endmodule

// File: doc/sb_mem_slave.md
SB_MEM_SLAVE -- requirements
Module: sb_mem_slave

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h0000_0000: byte base address of the window; must be aligned to the window size.
REQ-002 Parameter MEM_WORDS_LOG2, default 10: window is 2^MEM_WORDS_LOG2 32-bit words.
REQ-003 Parameter READ_WAIT, default 2: wait cycles between request capture and the first read beat (0..15).
REQ-004 Parameter WRITE_WAIT, default 0: busy cycles at the start of a write (0..15).
REQ-005 sb_clock_i  in  1  single clock; all logic on its rising edge.
REQ-006 sb_reset_n_i  in  1  synchronous, active-low reset.
REQ-007 sb_begin_transaction_i  in  1  one-cycle request strobe.
REQ-008 sb_address_data_i  in  32  byte address on begin; write data on data-valid beats.
REQ-009 sb_burst_size_i  in  8  beats minus 1, sampled on begin.
REQ-010 sb_read_n_write_i  in  1  1 = read, sampled on begin.
REQ-011 sb_byte_enables_i  in  4  write lane enables, sampled on begin, applied to all beats.
REQ-012 sb_data_valid_i / sb_end_transaction_i / sb_error_i  in  1 each  master write beat / master end / arbiter error.
REQ-013 sb_address_data_o  out  32  read data; 0 when not driving a beat (wired-OR bus).
REQ-014 sb_data_valid_o / sb_end_transaction_o / sb_busy_o / sb_error_o  out  1 each  read beat / read end / write stall / range error.

Function
REQ-015 States: IDLE, RD_WAIT, RD_BURST, RD_END, WR_DATA, ERR.
REQ-016 Hit = address[31:MEM_WORDS_LOG2+2] equals the same field of BASE_ADDRESS; address[1:0] ignored; word index = address[MEM_WORDS_LOG2+1:2].
REQ-017 IDLE, begin with miss: no response, stay IDLE.
REQ-018 IDLE, begin with hit and index + burst_size > 2^MEM_WORDS_LOG2 - 1: go to ERR; sb_error_o high exactly one cycle; return to IDLE; no memory access.
REQ-019 IDLE, begin with hit, in range, read: latch index, beat count = burst_size + 1; enter RD_WAIT.
REQ-020 RD_WAIT lasts READ_WAIT cycles (0 = straight to RD_BURST the next cycle); memory prefetch of the first word happens here.
REQ-021 RD_BURST: one beat per cycle, no gaps; sb_data_valid_o = 1 and sb_address_data_o = mem[index]; index increments per beat; after the last beat go to RD_END.
REQ-022 RD_END: sb_end_transaction_o high one cycle; then IDLE.
REQ-023 IDLE, begin with hit, in range, write: enter WR_DATA; sb_busy_o high for the first WRITE_WAIT cycles of WR_DATA.
REQ-024 WR_DATA: a beat with sb_data_valid_i = 1 and sb_busy_o = 0 writes the enabled lanes of mem[index], then index increments; beats while busy are ignored; beats past the latched count are ignored.
REQ-025 WR_DATA exits to IDLE on sb_end_transaction_i; a beat in the same cycle as end is still written.
REQ-026 In any non-IDLE state, sb_error_i or sb_end_transaction_i from another agent aborts to IDLE next cycle; outputs are 0 from that cycle.
REQ-027 sb_begin_transaction_i outside IDLE is ignored.
REQ-028 Read-after-write to the same word in consecutive transactions returns the new data.

Reset
REQ-029 While sb_reset_n_i = 0 at a clock edge: state IDLE, counters 0, all outputs 0 the next cycle; memory contents are not cleared.
REQ-030 Reset mid-burst truncates the burst with no end_transaction and no error.

Structure
REQ-031 Shared package sb_bus_pkg holds the state enum, the data width (32), the burst-size width (8), and the byte-enable width (4).
REQ-032 Storage is a sub-module sb_mem_ram: single-port, synchronous read, per-byte write enables, depth 2^MEM_WORDS_LOG2.

Verification
REQ-033 Read, default parameters: preload mem[0x400>>2] = 32'hDEAD_BEEF; begin 0x0000_0400, burst 0, read -> data_valid with DEAD_BEEF 3 cycles after begin, end_transaction the next cycle.
REQ-034 Write then read at 0x10, burst 3, enables 4'hF, data 1,2,3,4 -> read back 1,2,3,4 on 4 consecutive beats.
REQ-035 Byte-lane write: enables 4'b0101, data 32'hAABB_CCDD over word 32'h1122_3344 -> reads 32'h11BB_33DD.
REQ-036 Range error: begin 0x0000_0FFC, burst 1 -> sb_error_o single pulse, no data_valid, word unchanged.
REQ-037 WRITE_WAIT = 3: data_valid beats during busy are ignored; the first write lands on the first non-busy cycle.
REQ-038 Reset asserted during beat 2 of an 8-beat read -> outputs 0 next cycle; a new read completes normally after reset.
